// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage (core) and an
// external requester (ext); core has priority, ext has starvation and burst-lock guards.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, CORE, EXT, EXT_LOCKED} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic          core_grant, ext_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (ext_grant)
            state_nxt = ext_lock ? EXT_LOCKED : EXT;
        else if (core_grant)
            state_nxt = CORE;

        wait_nxt = '0;
        if (ext_req && !ext_grant)
            wait_nxt = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);

        // A locked grant taken after the forced release starts a fresh run at 1.
        lock_nxt = '0;
        if (ext_grant && ext_lock)
            lock_nxt = (lock_cnt >= LW'(MAX_LOCK)) ? LW'(1) : lock_cnt + LW'(1);
    end

    always_comb begin
        ext_grant = 1'b0;
        if (state == EXT_LOCKED && ext_req && lock_cnt < LW'(MAX_LOCK))
            ext_grant = 1'b1;
        else if (ext_req && wait_cnt == WW'(MAX_WAIT))
            ext_grant = 1'b1;
        else if (core_req)
            ext_grant = 1'b0;
        else if (ext_req)
            ext_grant = 1'b1;
        core_grant = core_req && !ext_grant;

        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ext_grant) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (core_grant) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end

        ext_gnt    = ext_grant;
        core_stall = core_req && !core_grant;
        core_rdata = core_grant ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_rdata  <= '0;
            ext_rvalid <= 1'b0;
        end else begin
            ext_rvalid <= ext_grant && !ext_we;
            if (ext_grant && !ext_we)
                ext_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-level behavioural model with its own memory
// image is compared every cycle, plus literal expectations at the scenario milestones.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int MAX_LOCK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .ext_rvalid(ext_rvalid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data_Memory stand-in: combinational read, write on the rising edge.
    bit [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who may use memory this cycle, from counts of waiting and locked runs.
    bit [31:0]   mmem [0:255];
    bit          m_lockprev = 1'b0;
    int          m_wait = 0;
    int          m_run = 0;
    bit          m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          ew, cw, e_we;
    logic [31:0] e_addr, e_wd, e_crd;

    always @(negedge clk) begin
        if (rst) begin
            m_lockprev = 1'b0; m_wait = 0; m_run = 0; m_rvalid = 1'b0; m_rdata = '0;
        end
        ew = ext_req && ((m_lockprev && m_run < MAX_LOCK) || m_wait >= MAX_WAIT || !core_req);
        cw = core_req && !ew;
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (ew) begin
            e_we = ext_we; e_addr = ext_addr; e_wd = ext_wdata;
        end else if (cw) begin
            e_we = core_we; e_addr = core_addr; e_wd = core_wdata;
        end
        e_crd = cw ? mmem[core_addr[9:2]] : 32'h0;
        chk("m_ext_gnt", ext_gnt, ew);
        chk("m_core_stall", core_stall, core_req && !cw);
        chk("m_core_rdata", core_rdata, e_crd);
        chk("m_mem_bus", {mem_we, mem_addr, mem_wdata}, {e_we, e_addr, e_wd});
        chk("m_ext_rd", {ext_rvalid, ext_rdata}, {m_rvalid, m_rdata});
        if (!rst) begin
            m_rvalid = ew && !ext_we;
            if (m_rvalid) m_rdata = mmem[ext_addr[9:2]];
            m_wait = (ext_req && !ew) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
            m_run = (ew && ext_lock) ? ((m_run >= MAX_LOCK) ? 1 : m_run + 1) : 0;
            m_lockprev = ew && ext_lock;
        end
        if (e_we) mmem[e_addr[9:2]] = e_wd;
    end

    task automatic nclk(); @(negedge clk); #1; endtask
    task automatic pclk(); @(posedge clk); #1; endtask
    task automatic cyc(); nclk(); pclk(); endtask

    task automatic set_core(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_ext(input bit req, input bit we, input bit lk, input logic [31:0] a,
                           input logic [31:0] d);
        ext_req = req; ext_we = we; ext_lock = lk; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        // 1: reset and idle
        nclk();
        chk("t1_rst_outs", {core_rdata, core_stall, ext_gnt, ext_rdata, ext_rvalid, mem_we,
                            mem_addr, mem_wdata}, '0);
        pclk();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nclk();
            chk("t1_idle_outs", {core_rdata, core_stall, ext_gnt, ext_rdata, ext_rvalid,
                                 mem_we, mem_addr, mem_wdata}, '0);
            pclk();
        end

        // 2: preload through core writes, then same-cycle core read
        set_core(1, 1, 32'h10, 32'hDEADBEEF); cyc();
        set_core(1, 1, 32'h20, 32'hCAFEF00D); cyc();
        set_core(1, 0, 32'h10, 32'h0);
        nclk();
        chk("t2_stall", core_stall, 1'b0);
        chk("t2_rdata", core_rdata, 32'hDEADBEEF);
        pclk();

        // 3: starvation guard forces ext in on the fifth cycle
        set_ext(1, 0, 0, 32'h20, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            nclk();
            chk("t3_core_owns", {ext_gnt, core_stall}, 2'b00);
            pclk();
        end
        nclk();
        chk("t3_ext_forced", {ext_gnt, core_stall}, 2'b11);
        chk("t3_addr", mem_addr, 32'h20);
        pclk();
        set_ext(0, 0, 0, 32'h0, 32'h0);
        nclk();
        chk("t3_rvalid", {ext_rvalid, ext_rdata}, {1'b1, 32'hCAFEF00D});
        chk("t3_core_back", core_stall, 1'b0);
        pclk();
        set_core(0, 0, 32'h0, 32'h0); cyc();

        // 4: locked write burst is released after MAX_LOCK grants
        for (int i = 0; i < 8; i++) begin
            set_ext(1, 1, 1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            set_core(i != 0, 0, 32'h10, 32'h0);
            nclk();
            chk("t4_burst_gnt", {ext_gnt, core_stall}, {1'b1, i != 0});
            pclk();
        end
        set_ext(1, 1, 1, 32'h120, 32'hB000_0008);
        nclk();
        chk("t4_release", {ext_gnt, core_stall}, 2'b00);
        chk("t4_core_rd", core_rdata, 32'hDEADBEEF);
        pclk();
        set_ext(0, 0, 0, 32'h0, 32'h0);
        set_core(0, 0, 32'h0, 32'h0);
        nclk();
        chk("t4_mem_first", mem[64], 32'hB000_0000);
        chk("t4_mem_last", mem[71], 32'hB000_0007);
        pclk();

        // 5: same-address write collision; core first, ext retries
        set_core(1, 1, 32'h40, 32'h1111);
        set_ext(1, 1, 0, 32'h40, 32'h2222);
        nclk();
        chk("t5_core_wr", {mem_we, mem_wdata, ext_gnt}, {1'b1, 32'h1111, 1'b0});
        pclk();
        set_core(0, 0, 32'h0, 32'h0);
        nclk();
        chk("t5_ext_wr", {mem_we, mem_wdata, ext_gnt}, {1'b1, 32'h2222, 1'b1});
        pclk();
        set_ext(0, 0, 0, 32'h0, 32'h0);
        set_core(1, 0, 32'h40, 32'h0);
        nclk();
        chk("t5_final", mem[16], 32'h2222);
        chk("t5_readback", core_rdata, 32'h2222);
        pclk();
        set_core(0, 0, 32'h0, 32'h0); cyc();

        // 6: async reset in the middle of a locked read burst
        set_ext(1, 0, 1, 32'h100, 32'h0);
        nclk();
        chk("t6_c1_gnt", ext_gnt, 1'b1);
        pclk();
        set_core(1, 0, 32'h10, 32'h0);
        ext_addr = 32'h104;
        nclk();
        chk("t6_c2", {ext_gnt, ext_rvalid, ext_rdata}, {1'b1, 1'b1, 32'hB000_0000});
        pclk();
        ext_addr = 32'h108;
        #1;
        chk("t6_c3_pre", {ext_gnt, ext_rvalid}, 2'b11);
        rst = 1'b1;
        #1;
        chk("t6_rst_drop", {ext_gnt, ext_rvalid, core_stall}, 3'b000);
        nclk();
        pclk();
        rst = 1'b0;
        nclk();
        chk("t6_core_first", {core_stall, ext_gnt, core_rdata}, {2'b00, 32'hDEADBEEF});
        pclk();
        set_core(0, 0, 32'h0, 32'h0); cyc();
        set_ext(0, 0, 0, 32'h0, 32'h0); cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
